bcd_counter: RTL and testbench



---
 rtl/bcd_pkg.sv | 18 +
 rtl/bcd_counter_if.sv | 32 +++
 rtl/bcd_digit.sv | 53 +++++
 rtl/bcd_counter.sv | 93 +++++++++
 tb/tb_bcd_counter.sv | 254 +++++++++++++++++++++++++
 5 files changed

// File: rtl/bcd_pkg.sv
// Shared types, constants and helpers for the BCD decade counter.
//   bcd_digit_t : one 4-bit BCD digit
//   BCD_MAX/MIN : digit range limits
//   bcd_valid() : 1 when a nibble is a legal BCD digit (0..9)
package bcd_pkg;

  localparam int unsigned BCD_W = 4;

  typedef logic [BCD_W-1:0] bcd_digit_t;

  localparam bcd_digit_t BCD_MAX = 4'd9;
  localparam bcd_digit_t BCD_MIN = 4'd0;

  function automatic logic bcd_valid(input bcd_digit_t d);
    return (d <= BCD_MAX);
  endfunction

endpackage

// File: rtl/bcd_counter_if.sv
// Control/data bundle between a counter user (master) and bcd_counter (slave).
//   en, up, load, load_val : master -> counter controls and load payload
//   q, upd, tc, load_err   : counter -> master value and status
//   tc is combinational; the rest of the counter outputs are registered.
interface bcd_counter_if
  import bcd_pkg::*;
#(
  parameter int unsigned DIGITS = 2
);

  localparam int unsigned W = BCD_W * DIGITS;

  logic         en;
  logic         up;
  logic         load;
  logic [W-1:0] load_val;
  logic [W-1:0] q;
  logic         upd;
  logic         tc;
  logic         load_err;

  modport master (
    output en, up, load, load_val,
    input  q, upd, tc, load_err
  );

  modport slave (
    input  en, up, load, load_val,
    output q, upd, tc, load_err
  );

endinterface

// File: rtl/bcd_digit.sv
// One decade stage of the BCD counter.
//   clk, rst_n  : clock, synchronous active-low reset
//   cin_i       : step request (all lower digits at terminal and counting)
//   up_i        : direction, 1 = up, 0 = down
//   load_i      : accepted parallel load (already validated by the top)
//   ld_digit_i  : digit value to load
//   digit_o     : registered digit value
//   term_o      : digit sits at the terminal value for the current direction
//   cout_o      : step request for the next digit (term_o & cin_i)
module bcd_digit
  import bcd_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cin_i,
  input  logic       up_i,
  input  logic       load_i,
  input  bcd_digit_t ld_digit_i,
  output bcd_digit_t digit_o,
  output logic       term_o,
  output logic       cout_o
);

  bcd_digit_t digit_q;
  bcd_digit_t digit_d;

  assign term_o  = up_i ? (digit_q == BCD_MAX) : (digit_q == BCD_MIN);
  assign cout_o  = cin_i & term_o;
  assign digit_o = digit_q;

  // Next digit: load has priority over stepping; wrap at the terminal value.
  always_comb begin
    digit_d = digit_q;
    if (load_i) begin
      digit_d = ld_digit_i;
    end else if (cin_i) begin
      if (up_i) begin
        digit_d = (digit_q == BCD_MAX) ? BCD_MIN : digit_q + 4'd1;
      end else begin
        digit_d = (digit_q == BCD_MIN) ? BCD_MAX : digit_q - 4'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      digit_q <= BCD_MIN;
    end else begin
      digit_q <= digit_d;
    end
  end

endmodule

// File: rtl/bcd_counter.sv
// Multi-digit BCD decade counter with enable, validated parallel load and
// optional down-counting.
//   clk, rst_n : clock, synchronous active-low reset
//   bus        : bcd_counter_if.slave (en, up, load, load_val -> q, upd, tc, load_err)
// Optional feature macro: BCD_COUNTER_DOWN_EN builds down-count support and
// makes bus.up select the direction; without it the counter is up-only.
module bcd_counter
  import bcd_pkg::*;
#(
  parameter int unsigned DIGITS = 2
)(
  input  logic          clk,
  input  logic          rst_n,
  bcd_counter_if.slave  bus
);

  logic              dir_up;
  logic              load_ok;
  logic              load_acc;
  logic [DIGITS:0]   carry;
  logic [DIGITS-1:0] term;
  logic              upd_q;
  logic              upd_d;
  logic              load_err_q;
  logic              load_err_d;
  logic              unused_carry;

`ifdef BCD_COUNTER_DOWN_EN
  assign dir_up = bus.up;
`else
  logic unused_up;
  assign dir_up    = 1'b1;
  assign unused_up = bus.up;
`endif

  // A load is only taken when every nibble is legal BCD.
  always_comb begin
    load_ok = 1'b1;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (!bcd_valid(bus.load_val[i*BCD_W +: BCD_W])) begin
        load_ok = 1'b0;
      end
    end
  end

  assign load_acc = bus.load & load_ok;

  // en is ignored whenever load is high, even for a rejected load.
  assign carry[0]     = bus.en & ~bus.load;
  assign unused_carry = carry[DIGITS];

  for (genvar g = 0; g < DIGITS; g++) begin : g_digit
    bcd_digit u_digit (
      .clk        (clk),
      .rst_n      (rst_n),
      .cin_i      (carry[g]),
      .up_i       (dir_up),
      .load_i     (load_acc),
      .ld_digit_i (bus.load_val[g*BCD_W +: BCD_W]),
      .digit_o    (bus.q[g*BCD_W +: BCD_W]),
      .term_o     (term[g]),
      .cout_o     (carry[g+1])
    );
  end

  assign bus.tc = bus.en & (&term);

  // Status strobes, aligned with the q update they describe.
  always_comb begin
    upd_d      = 1'b0;
    load_err_d = 1'b0;
    if (bus.load) begin
      upd_d      = load_ok;
      load_err_d = ~load_ok;
    end else if (bus.en) begin
      upd_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      upd_q      <= 1'b0;
      load_err_q <= 1'b0;
    end else begin
      upd_q      <= upd_d;
      load_err_q <= load_err_d;
    end
  end

  assign bus.upd      = upd_q;
  assign bus.load_err = load_err_q;

endmodule

// File: tb/tb_bcd_counter.sv
// Self-checking bench for bcd_counter (DIGITS=2) using an expected-value queue.
module tb_bcd_counter;

  logic clk;
  logic rst_n;

  bcd_counter_if #(.DIGITS(2)) bus ();

  bcd_counter #(.DIGITS(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct packed {
    logic [7:0] q;
    logic       upd;
    logic       err;
    logic       tc;
  } exp_t;

  typedef struct packed {
    logic       e;
    logic       l;
    logic [7:0] lv;
    logic       u;
    logic       r;
  } stim_t;

  exp_t       sb[$];
  logic [7:0] m_q;
  logic       tc_obs;
  int         checks = 0;
  int         errors = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int bcd2int(input logic [7:0] v);
    return int'(v[7:4]) * 10 + int'(v[3:0]);
  endfunction

  function automatic logic [7:0] int2bcd(input int n);
    return {4'(n / 10), 4'(n % 10)};
  endfunction

  // Drive one cycle of stimulus, predict the result into the queue.
  task automatic drive(input stim_t s);
    int   v;
    logic dir_up;
    exp_t x;
    @(negedge clk);
    rst_n        = s.r;
    bus.en       = s.e;
    bus.load     = s.l;
    bus.load_val = s.lv;
    bus.up       = s.u;
`ifdef BCD_COUNTER_DOWN_EN
    dir_up = s.u;
`else
    dir_up = 1'b1;
`endif
    v    = bcd2int(m_q);
    x.tc = s.e & (dir_up ? (v == 99) : (v == 0));
    x.upd = 1'b0;
    x.err = 1'b0;
    if (!s.r) begin
      m_q = 8'h00;
    end else if (s.l) begin
      if (s.lv[7:4] <= 4'd9 && s.lv[3:0] <= 4'd9) begin
        m_q   = s.lv;
        x.upd = 1'b1;
      end else begin
        x.err = 1'b1;
      end
    end else if (s.e) begin
      m_q   = int2bcd(dir_up ? (v + 1) % 100 : (v + 99) % 100);
      x.upd = 1'b1;
    end
    x.q = m_q;
    sb.push_back(x);
    #1 tc_obs = bus.tc;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    exp_t x;
    for (int i = 0; i < 2; i++) begin
      drive('{1'b0, 1'b0, 8'h00, 1'b1, 1'b0});
      x = sb.pop_front();
      checks++;
      if ({bus.q, bus.upd, bus.load_err, tc_obs} !== x) begin
        errors++;
        $display("FAIL reset[%0d] got q=%h upd=%b err=%b tc=%b expected q=%h upd=%b err=%b tc=%b",
                 i, bus.q, bus.upd, bus.load_err, tc_obs, x.q, x.upd, x.err, x.tc);
      end
    end
  endtask

  task automatic test_count();
    exp_t x;
    for (int i = 0; i < 12; i++) begin
      drive('{1'b1, 1'b0, 8'h00, 1'b1, 1'b1});
      x = sb.pop_front();
      checks++;
      if ({bus.q, bus.upd, bus.load_err, tc_obs} !== x || bus.q[7:4] > 4'd9 || bus.q[3:0] > 4'd9) begin
        errors++;
        $display("FAIL count[%0d] got q=%h upd=%b err=%b tc=%b expected q=%h upd=%b err=%b tc=%b",
                 i, bus.q, bus.upd, bus.load_err, tc_obs, x.q, x.upd, x.err, x.tc);
      end
    end
  endtask

  task automatic test_up_wrap();
    stim_t s [4] = '{'{1'b0, 1'b1, 8'h98, 1'b1, 1'b1},
                     '{1'b1, 1'b0, 8'h00, 1'b1, 1'b1},
                     '{1'b1, 1'b0, 8'h00, 1'b1, 1'b1},
                     '{1'b1, 1'b0, 8'h00, 1'b1, 1'b1}};
    exp_t x;
    foreach (s[i]) begin
      drive(s[i]);
      x = sb.pop_front();
      checks++;
      if ({bus.q, bus.upd, bus.load_err, tc_obs} !== x) begin
        errors++;
        $display("FAIL up_wrap[%0d] got q=%h upd=%b err=%b tc=%b expected q=%h upd=%b err=%b tc=%b",
                 i, bus.q, bus.upd, bus.load_err, tc_obs, x.q, x.upd, x.err, x.tc);
      end
    end
  endtask

  task automatic test_rejected_load();
    stim_t s [5] = '{'{1'b0, 1'b1, 8'h42, 1'b1, 1'b1},
                     '{1'b1, 1'b1, 8'h3A, 1'b1, 1'b1},
                     '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1},
                     '{1'b0, 1'b1, 8'hA0, 1'b1, 1'b1},
                     '{1'b0, 1'b1, 8'hFF, 1'b1, 1'b1}};
    exp_t x;
    foreach (s[i]) begin
      drive(s[i]);
      x = sb.pop_front();
      checks++;
      if ({bus.q, bus.upd, bus.load_err, tc_obs} !== x) begin
        errors++;
        $display("FAIL rej_load[%0d] got q=%h upd=%b err=%b tc=%b expected q=%h upd=%b err=%b tc=%b",
                 i, bus.q, bus.upd, bus.load_err, tc_obs, x.q, x.upd, x.err, x.tc);
      end
    end
  endtask

  task automatic test_load_beats_en();
    stim_t s [3] = '{'{1'b1, 1'b1, 8'h57, 1'b1, 1'b1},
                     '{1'b1, 1'b0, 8'h00, 1'b1, 1'b1},
                     '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1}};
    exp_t x;
    foreach (s[i]) begin
      drive(s[i]);
      x = sb.pop_front();
      checks++;
      if ({bus.q, bus.upd, bus.load_err, tc_obs} !== x) begin
        errors++;
        $display("FAIL load_beats_en[%0d] got q=%h upd=%b err=%b tc=%b expected q=%h upd=%b err=%b tc=%b",
                 i, bus.q, bus.upd, bus.load_err, tc_obs, x.q, x.upd, x.err, x.tc);
      end
    end
  endtask

  task automatic test_down();
    stim_t s [5] = '{'{1'b0, 1'b1, 8'h01, 1'b0, 1'b1},
                     '{1'b1, 1'b0, 8'h00, 1'b0, 1'b1},
                     '{1'b1, 1'b0, 8'h00, 1'b0, 1'b1},
                     '{1'b1, 1'b0, 8'h00, 1'b0, 1'b1},
                     '{1'b1, 1'b0, 8'h00, 1'b1, 1'b1}};
    exp_t x;
    foreach (s[i]) begin
      drive(s[i]);
      x = sb.pop_front();
      checks++;
      if ({bus.q, bus.upd, bus.load_err, tc_obs} !== x) begin
        errors++;
        $display("FAIL down[%0d] got q=%h upd=%b err=%b tc=%b expected q=%h upd=%b err=%b tc=%b",
                 i, bus.q, bus.upd, bus.load_err, tc_obs, x.q, x.upd, x.err, x.tc);
      end
    end
  endtask

  task automatic test_reset_mid();
    stim_t s [5] = '{'{1'b0, 1'b1, 8'h37, 1'b1, 1'b1},
                     '{1'b1, 1'b0, 8'h00, 1'b1, 1'b0},
                     '{1'b1, 1'b0, 8'h00, 1'b1, 1'b1},
                     '{1'b0, 1'b1, 8'h4B, 1'b1, 1'b1},
                     '{1'b1, 1'b1, 8'h66, 1'b1, 1'b0}};
    exp_t x;
    foreach (s[i]) begin
      drive(s[i]);
      x = sb.pop_front();
      checks++;
      if ({bus.q, bus.upd, bus.load_err, tc_obs} !== x) begin
        errors++;
        $display("FAIL reset_mid[%0d] got q=%h upd=%b err=%b tc=%b expected q=%h upd=%b err=%b tc=%b",
                 i, bus.q, bus.upd, bus.load_err, tc_obs, x.q, x.upd, x.err, x.tc);
      end
    end
  endtask

  task automatic test_back_to_back();
    exp_t x;
    for (int i = 0; i < 16; i++) begin
      stim_t s;
      s.e  = 1'b1;
      s.l  = (i % 4 == 0);
      s.lv = {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
      s.u  = 1'($urandom_range(0, 1));
      s.r  = 1'b1;
      if (i == 15) s.lv = 8'h99;
      drive(s);
      x = sb.pop_front();
      checks++;
      if ({bus.q, bus.upd, bus.load_err, tc_obs} !== x) begin
        errors++;
        $display("FAIL back_to_back[%0d] got q=%h upd=%b err=%b tc=%b expected q=%h upd=%b err=%b tc=%b",
                 i, bus.q, bus.upd, bus.load_err, tc_obs, x.q, x.upd, x.err, x.tc);
      end
    end
  endtask

  initial begin
    m_q          = 8'h00;
    tc_obs       = 1'b0;
    rst_n        = 1'b0;
    bus.en       = 1'b0;
    bus.up       = 1'b1;
    bus.load     = 1'b0;
    bus.load_val = 8'h00;
    test_reset();
    test_count();
    test_up_wrap();
    test_rejected_load();
    test_load_beats_en();
    test_down();
    test_reset_mid();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired at %0t, checks=%0d", $time, checks);
    $fatal(1, "timeout");
  end

endmodule
